// File: rtl/ex_stage.sv
// Execute stage of the 8-bit pipelined core: ALU, C/Z flags, conditional
// branch resolution and the registered EX/MEM pipeline boundary.
module ex_stage #(
  parameter int DATA_W  = 8,
  parameter int INSTR_W = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  ID_EX_A,
  input  logic [DATA_W-1:0]  ID_EX_B,
  input  logic [INSTR_W-1:0] ID_EX_instruction,
  input  logic               ID_EX_mem_write,
  input  logic               ID_EX_reg_write,
  input  logic               ID_EX_alu_use_carry,
  input  logic               ID_EX_alu_B_mux,
  input  logic               ID_EX_select_c,
  input  logic               ID_EX_select_z,
  input  logic               ID_EX_write_c,
  input  logic               ID_EX_write_z,
  input  logic [2:0]         ID_EX_alu_op,
  input  logic [1:0]         ID_EX_reg_write_mux,
  input  logic               stall,
  input  logic               flush,
  output logic [DATA_W-1:0]  EX_MEM_alu_result,
  output logic [DATA_W-1:0]  EX_MEM_B,
  output logic [INSTR_W-1:0] EX_MEM_instruction,
  output logic               EX_MEM_mem_write,
  output logic               EX_MEM_reg_write,
  output logic [1:0]         EX_MEM_reg_write_mux,
  output logic               EX_MEM_branch_taken,
  output logic [DATA_W-1:0]  EX_MEM_branch_target,
  output logic               carry_flag,
  output logic               zero_flag
);

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SHL  = 3'd5,
    ALU_SHR  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_e;

  logic [DATA_W-1:0]  r_alu_result;
  logic [DATA_W-1:0]  r_b;
  logic [INSTR_W-1:0] r_instruction;
  logic               r_mem_write;
  logic               r_reg_write;
  logic [1:0]         r_reg_write_mux;
  logic               r_branch_taken;
  logic [DATA_W-1:0]  r_branch_target;
  logic               r_carry;
  logic               r_zero;

  logic [DATA_W-1:0]  w_bop;
  logic               w_cin;
  logic [DATA_W:0]    w_sum;
  logic [DATA_W:0]    w_diff;
  logic [DATA_W-1:0]  w_result;
  logic               w_carry;
  logic               w_zero;
  logic               w_taken;

  always_comb begin
    w_bop    = ID_EX_alu_B_mux ? ID_EX_instruction[DATA_W-1:0] : ID_EX_B;
    w_cin    = ID_EX_alu_use_carry & r_carry;
    // Bit DATA_W of the 9-bit difference is the borrow, since A-(Bop+cin) wraps negative.
    w_sum    = {1'b0, ID_EX_A} + {1'b0, w_bop} + {{DATA_W{1'b0}}, w_cin};
    w_diff   = {1'b0, ID_EX_A} - {1'b0, w_bop} - {{DATA_W{1'b0}}, w_cin};
    w_result = '0;
    w_carry  = 1'b0;
    case (alu_op_e'(ID_EX_alu_op))
      ALU_ADD:  begin w_result = w_sum[DATA_W-1:0];  w_carry = w_sum[DATA_W];  end
      ALU_SUB:  begin w_result = w_diff[DATA_W-1:0]; w_carry = w_diff[DATA_W]; end
      ALU_AND:  w_result = ID_EX_A & w_bop;
      ALU_OR:   w_result = ID_EX_A | w_bop;
      ALU_XOR:  w_result = ID_EX_A ^ w_bop;
      ALU_SHL:  begin w_result = {ID_EX_A[DATA_W-2:0], 1'b0}; w_carry = ID_EX_A[DATA_W-1]; end
      ALU_SHR:  begin w_result = {1'b0, ID_EX_A[DATA_W-1:1]}; w_carry = ID_EX_A[0]; end
      ALU_PASS: w_result = w_bop;
      default:  w_result = '0;
    endcase
    w_zero  = (w_result == '0);
    // Branch sees the flags as left by earlier instructions, not this one.
    w_taken = (ID_EX_select_c & r_carry) | (ID_EX_select_z & r_zero);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_result    <= '0;
      r_b             <= '0;
      r_instruction   <= '0;
      r_mem_write     <= 1'b0;
      r_reg_write     <= 1'b0;
      r_reg_write_mux <= '0;
      r_branch_taken  <= 1'b0;
      r_branch_target <= '0;
      r_carry         <= 1'b0;
      r_zero          <= 1'b0;
    end else if (flush) begin
      // Bubble: everything downstream sees a no-op; flags are untouched.
      r_alu_result    <= '0;
      r_b             <= '0;
      r_instruction   <= '0;
      r_mem_write     <= 1'b0;
      r_reg_write     <= 1'b0;
      r_reg_write_mux <= '0;
      r_branch_taken  <= 1'b0;
      r_branch_target <= '0;
    end else if (!stall) begin
      r_alu_result    <= w_result;
      r_b             <= ID_EX_B;
      r_instruction   <= ID_EX_instruction;
      r_mem_write     <= ID_EX_mem_write;
      r_reg_write     <= ID_EX_reg_write;
      r_reg_write_mux <= ID_EX_reg_write_mux;
      r_branch_taken  <= w_taken;
      r_branch_target <= ID_EX_instruction[DATA_W-1:0];
      if (ID_EX_write_c) r_carry <= w_carry;
      if (ID_EX_write_z) r_zero  <= w_zero;
    end
  end

  assign EX_MEM_alu_result    = r_alu_result;
  assign EX_MEM_B             = r_b;
  assign EX_MEM_instruction   = r_instruction;
  assign EX_MEM_mem_write     = r_mem_write;
  assign EX_MEM_reg_write     = r_reg_write;
  assign EX_MEM_reg_write_mux = r_reg_write_mux;
  assign EX_MEM_branch_taken  = r_branch_taken;
  assign EX_MEM_branch_target = r_branch_target;
  assign carry_flag           = r_carry;
  assign zero_flag            = r_zero;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases followed by randomized traffic, all
// checked against an arithmetic reference model of the execute stage.
module tb_ex_stage;

  logic        clk;
  logic        reset;
  logic [7:0]  a, b;
  logic [18:0] instr;
  logic        mem_write, reg_write, use_carry, b_mux;
  logic        sel_c, sel_z, write_c, write_z;
  logic [2:0]  alu_op;
  logic [1:0]  rw_mux;
  logic        stall, flush;

  logic [7:0]  o_res, o_b, o_tgt;
  logic [18:0] o_ins;
  logic        o_mw, o_rw, o_bt, o_c, o_z;
  logic [1:0]  o_rwm;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: the expected EX/MEM contents and flags.
  logic [7:0]  m_res, m_b, m_tgt;
  logic [18:0] m_ins;
  logic        m_mw, m_rw, m_bt, m_c, m_z;
  logic [1:0]  m_rwm;

  logic [49:0] exp_q[$];

  ex_stage dut (
    .clk(clk), .reset(reset),
    .ID_EX_A(a), .ID_EX_B(b), .ID_EX_instruction(instr),
    .ID_EX_mem_write(mem_write), .ID_EX_reg_write(reg_write),
    .ID_EX_alu_use_carry(use_carry), .ID_EX_alu_B_mux(b_mux),
    .ID_EX_select_c(sel_c), .ID_EX_select_z(sel_z),
    .ID_EX_write_c(write_c), .ID_EX_write_z(write_z),
    .ID_EX_alu_op(alu_op), .ID_EX_reg_write_mux(rw_mux),
    .stall(stall), .flush(flush),
    .EX_MEM_alu_result(o_res), .EX_MEM_B(o_b), .EX_MEM_instruction(o_ins),
    .EX_MEM_mem_write(o_mw), .EX_MEM_reg_write(o_rw),
    .EX_MEM_reg_write_mux(o_rwm), .EX_MEM_branch_taken(o_bt),
    .EX_MEM_branch_target(o_tgt), .carry_flag(o_c), .zero_flag(o_z)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic alu_ref(input int op, input int x, input int y, input int cin,
                         output int res, output int c);
    int s;
    c = 0;
    case (op)
      0: begin s = x + y + cin; res = s % 256; c = (s > 255) ? 1 : 0; end
      1: begin s = x - y - cin; res = (s + 512) % 256; c = (s < 0) ? 1 : 0; end
      2: res = x & y;
      3: res = x | y;
      4: res = x ^ y;
      5: begin res = (x * 2) % 256; c = x / 128; end
      6: begin res = x / 2; c = x % 2; end
      default: res = y;
    endcase
  endtask

  // Advance the model by one edge, clock the DUT, compare every output.
  task automatic step();
    int bop, cin, res, c;
    logic [49:0] e;
    if (reset) begin
      {m_res, m_b, m_ins, m_mw, m_rw, m_rwm, m_bt, m_tgt, m_c, m_z} = '0;
    end else if (flush) begin
      {m_res, m_b, m_ins, m_mw, m_rw, m_rwm, m_bt, m_tgt} = '0;
    end else if (!stall) begin
      bop = b_mux ? int'(instr[7:0]) : int'(b);
      cin = (use_carry && m_c) ? 1 : 0;
      alu_ref(int'(alu_op), int'(a), bop, cin, res, c);
      m_bt  = (sel_c && m_c) || (sel_z && m_z);
      m_res = res[7:0];
      m_b   = b;
      m_ins = instr;
      m_mw  = mem_write;
      m_rw  = reg_write;
      m_rwm = rw_mux;
      m_tgt = instr[7:0];
      if (write_c) m_c = (c != 0);
      if (write_z) m_z = (res == 0);
    end
    exp_q.push_back({m_res, m_b, m_ins, m_mw, m_rw, m_rwm, m_bt, m_tgt, m_c, m_z});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("alu_result", 32'(o_res), 32'(e[49:42]));
    check("ex_mem_b",   32'(o_b),   32'(e[41:34]));
    check("instr",      32'(o_ins), 32'(e[33:15]));
    check("mem_write",  32'(o_mw),  32'(e[14]));
    check("reg_write",  32'(o_rw),  32'(e[13]));
    check("rw_mux",     32'(o_rwm), 32'(e[12:11]));
    check("br_taken",   32'(o_bt),  32'(e[10]));
    check("br_target",  32'(o_tgt), 32'(e[9:2]));
    check("carry",      32'(o_c),   32'(e[1]));
    check("zero",       32'(o_z),   32'(e[0]));
  endtask

  task automatic idle();
    reset = 0; stall = 0; flush = 0;
    a = 0; b = 0; instr = 0; alu_op = 0; rw_mux = 0;
    mem_write = 0; reg_write = 0; use_carry = 0; b_mux = 0;
    sel_c = 0; sel_z = 0; write_c = 0; write_z = 0;
  endtask

  task automatic drive_op(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv,
                          input logic wc, input logic wz);
    idle();
    alu_op = op; a = av; b = bv; write_c = wc; write_z = wz;
  endtask

  initial begin
    logic [7:0] s_res;
    logic       s_c, s_z;

    // Reset with every input nonzero.
    idle();
    reset = 1; stall = 1; flush = 1;
    a = 8'hFF; b = 8'hFF; instr = 19'h7FFFF; alu_op = 3'd7; rw_mux = 2'd3;
    mem_write = 1; reg_write = 1; use_carry = 1; b_mux = 1;
    sel_c = 1; sel_z = 1; write_c = 1; write_z = 1;
    step();
    check("rst_result", 32'(o_res), 32'h0);
    check("rst_instr",  32'(o_ins), 32'h0);
    check("rst_flags",  32'({o_c, o_z}), 32'h0);
    reset = 0; flush = 0;
    step();
    check("rst_stall_rw", 32'(o_rw), 32'h0);

    // ADD carry chain.
    drive_op(3'd0, 8'hFF, 8'h01, 1, 1);
    step();
    check("add_ff_res", 32'(o_res), 32'h00);
    check("add_ff_cz",  32'({o_c, o_z}), 32'h3);
    drive_op(3'd0, 8'h10, 8'h20, 1, 1);
    use_carry = 1;
    step();
    check("add_cin_res", 32'(o_res), 32'h31);
    check("add_cin_cz",  32'({o_c, o_z}), 32'h0);

    // SUB with immediate borrow; store data stays the register operand.
    drive_op(3'd1, 8'h05, 8'h99, 1, 0);
    b_mux = 1; instr = 19'h5A307;
    step();
    check("sub_imm_res", 32'(o_res), 32'hFE);
    check("sub_imm_c",   32'(o_c),   32'h1);
    check("sub_imm_b",   32'(o_b),   32'h99);

    // Branch on Z.
    drive_op(3'd0, 8'h00, 8'h00, 1, 1);
    step();
    drive_op(3'd7, 8'h00, 8'h55, 0, 0);
    sel_z = 1; instr = 19'h0003C;
    step();
    check("brz_taken",  32'(o_bt),  32'h1);
    check("brz_target", 32'(o_tgt), 32'h3C);
    drive_op(3'd7, 8'h00, 8'h11, 0, 1);
    step();
    drive_op(3'd7, 8'h00, 8'h11, 0, 0);
    sel_z = 1; instr = 19'h0003C;
    step();
    check("brz_not", 32'(o_bt), 32'h0);
    drive_op(3'd7, 8'h00, 8'h11, 0, 0);
    sel_c = 1; instr = 19'h00044;
    step();
    check("brc_not", 32'(o_bt), 32'h0);

    // Stall for three cycles with changing inputs.
    drive_op(3'd0, 8'h80, 8'h90, 1, 1);
    reg_write = 1; instr = 19'h12345;
    step();
    s_res = m_res; s_c = m_c; s_z = m_z;
    for (int i = 0; i < 3; i++) begin
      drive_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1, 1);
      instr = 19'($urandom); mem_write = 1;
      stall = 1;
      step();
      check("stall_res", 32'(o_res), 32'(s_res));
      check("stall_cz",  32'({o_c, o_z}), 32'({s_c, s_z}));
    end

    // Flush: bubble inserted, Z unchanged.
    drive_op(3'd0, 8'h00, 8'h00, 1, 1);
    step();
    drive_op(3'd0, 8'h01, 8'h01, 1, 1);
    reg_write = 1; mem_write = 1; flush = 1;
    step();
    check("flush_rw", 32'(o_rw), 32'h0);
    check("flush_mw", 32'(o_mw), 32'h0);
    check("flush_z",  32'(o_z),  32'h1);
    drive_op(3'd3, 8'h0F, 8'hF0, 1, 1);
    reg_write = 1; instr = 19'h7ABCD; stall = 1; flush = 1;
    step();
    check("stflush_rw",  32'(o_rw),  32'h0);
    check("stflush_ins", 32'(o_ins), 32'h0);

    // Shifts.
    drive_op(3'd5, 8'h81, 8'h00, 1, 1);
    step();
    check("shl_res", 32'(o_res), 32'h02);
    check("shl_c",   32'(o_c),   32'h1);
    drive_op(3'd6, 8'h81, 8'h00, 1, 1);
    step();
    check("shr_res", 32'(o_res), 32'h40);
    check("shr_c",   32'(o_c),   32'h1);
    drive_op(3'd6, 8'h00, 8'h00, 1, 1);
    step();
    check("shr0_res", 32'(o_res), 32'h00);
    check("shr0_cz",  32'({o_c, o_z}), 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      instr     = 19'($urandom);
      alu_op    = 3'($urandom_range(0, 7));
      rw_mux    = 2'($urandom_range(0, 3));
      mem_write = 1'($urandom);
      reg_write = 1'($urandom);
      use_carry = 1'($urandom);
      b_mux     = 1'($urandom);
      sel_c     = 1'($urandom);
      sel_z     = 1'($urandom);
      write_c   = 1'($urandom);
      write_z   = 1'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 8-bit pipelined core.
- Consumes the registered ID/EX fields: A, B, the 19-bit instruction and the control bits.
- Performs the ALU operation, maintains the architectural carry (C) and zero (Z) flags, and resolves C/Z-conditional branches.
- Registers the results into the EX/MEM pipeline boundary for the memory stage.
- Supports stall (hold) and flush (bubble) from the hazard logic.

Parameters:
- DATA_W, 8, datapath width of A, B and the ALU result.
- INSTR_W, 19, instruction width; bits [7:0] hold the immediate / branch target.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- ID_EX_A  in  8  operand A.
- ID_EX_B  in  8  operand B (register).
- ID_EX_instruction  in  19  instruction word.
- ID_EX_mem_write  in  1  store request.
- ID_EX_reg_write  in  1  register write request.
- ID_EX_alu_use_carry  in  1  ADD/SUB consume the C flag.
- ID_EX_alu_B_mux  in  1  0: B = ID_EX_B; 1: B = instruction[7:0].
- ID_EX_select_c  in  1  conditional branch on C.
- ID_EX_select_z  in  1  conditional branch on Z.
- ID_EX_write_c  in  1  update C.
- ID_EX_write_z  in  1  update Z.
- ID_EX_alu_op  in  3  ALU opcode.
- ID_EX_reg_write_mux  in  2  writeback source select (passed through).
- stall  in  1  hold all EX state this cycle.
- flush  in  1  insert bubble into EX/MEM this cycle.
- EX_MEM_alu_result  out  8  registered ALU result.
- EX_MEM_B  out  8  registered store data (ID_EX_B, never the immediate).
- EX_MEM_instruction  out  19  registered instruction.
- EX_MEM_mem_write  out  1  registered store request.
- EX_MEM_reg_write  out  1  registered register write request.
- EX_MEM_reg_write_mux  out  2  registered writeback select.
- EX_MEM_branch_taken  out  1  registered branch decision.
- EX_MEM_branch_target  out  8  registered instruction[7:0].
- carry_flag  out  1  architectural C.
- zero_flag  out  1  architectural Z.

Behaviour:
- Reset: on a clock edge with reset=1, all EX_MEM_* outputs and both flags go to 0. Reset beats stall and flush.
- Latency: 1 cycle. Inputs sampled at edge N appear on EX_MEM_* after edge N.
- Operand B: Bop = alu_B_mux ? instruction[7:0] : ID_EX_B. cin = alu_use_carry & carry_flag.
- ALU ops: all arithmetic is 9-bit; the result is the low 8 bits.
  - 0 ADD: A+Bop+cin; C = bit 8.
  - 1 SUB: A-Bop-cin; C = borrow (1 when A < Bop+cin).
  - 2 AND, 3 OR, 4 XOR: C = 0.
  - 5 SHL: A<<1; C = A[7].
  - 6 SHR: logical A>>1; C = A[0].
  - 7 PASS: result = Bop; C = 0.
- Zero: Z = (result == 0).
- Flag update: C (Z) takes its new value at the edge only if write_c (write_z) is set and stall=0 and flush=0. Otherwise the flag holds.
- Branch: taken = (select_c & carry_flag) | (select_z & zero_flag).
  - Uses the flag values before this instruction's own update.
  - A flag written by the immediately preceding instruction is already visible, because flags are registered.
- stall=1 (flush=0): every EX_MEM_* register and both flags hold their values.
- flush=1: the following outputs load 0:
  - EX_MEM_mem_write, EX_MEM_reg_write, EX_MEM_branch_taken, EX_MEM_instruction, EX_MEM_reg_write_mux.
  - Other data outputs are don't-care; the implementation loads 0.
  - Flags hold.
- stall and flush together: flush wins.
- No combinational path from any input to any output. All outputs are flops.

Test Plan:
- Reset: assert reset with all inputs nonzero for 1 edge -> every output 0. Deassert reset with stall=1 -> outputs stay 0.
- ADD carry chain:
  - Cycle 1: A=0xFF, B=0x01, op=ADD, write_c=write_z=1 -> EX_MEM_alu_result=0x00, C=1, Z=1.
  - Next cycle: A=0x10, B=0x20, alu_use_carry=1 -> result=0x31, C=0, Z=0.
- SUB borrow with immediate: A=0x05, instruction[7:0]=0x07, alu_B_mux=1, op=SUB, write_c=1 -> result=0xFE, C=1. EX_MEM_B equals ID_EX_B, not 0x07.
- Branch:
  - After an op leaving Z=1: select_z=1, instruction[7:0]=0x3C -> EX_MEM_branch_taken=1, target=0x3C.
  - Same with Z=0 -> taken=0.
  - select_c=1 with C=0 -> taken=0.
- Stall/flush:
  - Stall 3 cycles mid-stream, changing inputs -> outputs and flags frozen.
  - Flush with reg_write=mem_write=1, write_z=1 -> EX_MEM_reg_write=0, EX_MEM_mem_write=0, Z unchanged.
  - stall=flush=1 -> bubble is inserted.
- Shifts: A=0x81, SHL, write_c=1 -> result=0x02, C=1. A=0x81, SHR -> result=0x40, C=1. A=0x00, SHR -> result=0x00, Z=1, C=0.
